// File: rtl/pingpong_drain.sv
// Ping-pong FIFO drain: reads packets alternately from bank A and bank B.
// Optional sticky error detection is compiled in with PINGPONG_DRAIN_ERR_EN.
module pingpong_drain (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [12:0] packer_len,
  input  logic        enable,
  input  logic        wr_a,
  input  logic        wr_b,
  input  logic        empty_a,
  input  logic        empty_b,
  input  logic        out_rdy,
  output logic        fifo_rd1,
  output logic        fifo_rd2,
  output logic        fifo_rd3,
  output logic        fifo_rd4,
  output logic        data_valid,
  output logic        bank_sel,
  output logic        pkt_start,
  output logic        pkt_end,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_A,
    S_READ_A,
    S_WAIT_B,
    S_READ_B
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [12:0] r_len;
  logic [12:0] r_wcnt_a;
  logic [12:0] r_wcnt_b;
  logic [12:0] r_rcnt;
  logic [2:0]  r_pend_a;
  logic [2:0]  r_pend_b;
  logic        r_dv;
  logic        r_bank;
  logic        r_ps;
  logic        r_pe;

  logic [12:0] w_len_m1;
  logic        w_run;
  logic        w_trk;
  logic        w_rd_a;
  logic        w_rd_b;
  logic        w_rd;
  logic        w_last;
  logic        w_inc_a;
  logic        w_inc_b;
  logic        w_dec_a;
  logic        w_dec_b;
  logic        w_rd_start;
  logic        w_unused_ce;

  // ce is a legacy clock-enable input with no function
  assign w_unused_ce = ce;

  assign w_len_m1 = r_len - 13'd1;
  assign w_run    = enable & ~reset;
  assign w_trk    = w_run & (r_state != S_IDLE);
  assign w_rd_a   = w_run & (r_state == S_READ_A)
                  & out_rdy & ~empty_a;
  assign w_rd_b   = w_run & (r_state == S_READ_B)
                  & out_rdy & ~empty_b;
  assign w_rd     = w_rd_a | w_rd_b;
  assign w_last   = (r_rcnt == w_len_m1);
  assign w_inc_a  = w_trk & wr_a & (r_wcnt_a == w_len_m1);
  assign w_inc_b  = w_trk & wr_b & (r_wcnt_b == w_len_m1);
  assign w_dec_a  = w_rd_a & w_last;
  assign w_dec_b  = w_rd_b & w_last;
  assign w_rd_start =
    ((r_state == S_WAIT_A) && (w_next == S_READ_A)) ||
    ((r_state == S_WAIT_B) && (w_next == S_READ_B));

  assign fifo_rd1   = w_rd_a;
  assign fifo_rd2   = w_rd_a;
  assign fifo_rd3   = w_rd_b;
  assign fifo_rd4   = w_rd_b;
  assign data_valid = r_dv;
  assign bank_sel   = r_bank;
  assign pkt_start  = r_ps;
  assign pkt_end    = r_pe;

  // Next-state: strict A,B alternation; enable low forces IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (enable) w_next = S_WAIT_A;
      S_WAIT_A: if (r_pend_a != 3'd0) w_next = S_READ_A;
      S_READ_A: if (w_dec_a) w_next = S_WAIT_B;
      S_WAIT_B: if (r_pend_b != 3'd0) w_next = S_READ_B;
      S_READ_B: if (w_dec_b) w_next = S_WAIT_A;
      default:  w_next = S_IDLE;
    endcase
    if (!enable) w_next = S_IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Packet length captured when leaving IDLE; zero means one word
  always_ff @(posedge clk) begin
    if (reset)
      r_len <= 13'd0;
    else if (r_state == S_IDLE && enable)
      r_len <= (packer_len == 13'd0) ? 13'd1 : packer_len;
  end

  // Write-side word counters per bank
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_wcnt_a <= 13'd0;
      r_wcnt_b <= 13'd0;
    end else begin
      if (w_trk && wr_a)
        r_wcnt_a <= w_inc_a ? 13'd0 : r_wcnt_a + 13'd1;
      if (w_trk && wr_b)
        r_wcnt_b <= w_inc_b ? 13'd0 : r_wcnt_b + 13'd1;
    end
  end

  // Pending-packet counters, saturating at 7
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_pend_a <= 3'd0;
      r_pend_b <= 3'd0;
    end else begin
      unique case ({w_inc_a, w_dec_a})
        2'b10:   if (r_pend_a != 3'd7) r_pend_a <= r_pend_a + 3'd1;
        2'b01:   r_pend_a <= r_pend_a - 3'd1;
        default: r_pend_a <= r_pend_a;
      endcase
      unique case ({w_inc_b, w_dec_b})
        2'b10:   if (r_pend_b != 3'd7) r_pend_b <= r_pend_b + 3'd1;
        2'b01:   r_pend_b <= r_pend_b - 3'd1;
        default: r_pend_b <= r_pend_b;
      endcase
    end
  end

  // Read word counter within the current packet
  always_ff @(posedge clk) begin
    if (reset || !enable)
      r_rcnt <= 13'd0;
    else if (w_rd_start)
      r_rcnt <= 13'd0;
    else if (w_rd)
      r_rcnt <= w_last ? 13'd0 : r_rcnt + 13'd1;
  end

  // Output flags follow the strobe by one cycle (FIFO read latency)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dv   <= 1'b0;
      r_bank <= 1'b0;
      r_ps   <= 1'b0;
      r_pe   <= 1'b0;
    end else begin
      r_dv <= w_rd;
      r_ps <= w_rd & (r_rcnt == 13'd0);
      r_pe <= w_rd & w_last;
      if (w_rd) r_bank <= w_rd_b;
    end
  end

`ifdef PINGPONG_DRAIN_ERR_EN
  logic r_err;
  logic w_ovf;
  logic w_starve;

  assign w_ovf =
    (w_inc_a & ~w_dec_a & (r_pend_a == 3'd7)) |
    (w_inc_b & ~w_dec_b & (r_pend_b == 3'd7));
  assign w_starve = w_run & (
    ((r_state == S_READ_A) & w_last & empty_a & wr_a) |
    ((r_state == S_READ_B) & w_last & empty_b & wr_b));

  // Sticky error: pend overflow or last-word starvation
  always_ff @(posedge clk) begin
    if (reset)
      r_err <= 1'b0;
    else if (w_ovf || w_starve)
      r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_drain.sv
// Directed bench for pingpong_drain: vector table plus corner sequences.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_pingpong_drain;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic [12:0] packer_len = 13'd0;
  logic        enable = 1'b0;
  logic        wr_a = 1'b0;
  logic        wr_b = 1'b0;
  logic        empty_a = 1'b0;
  logic        empty_b = 1'b0;
  logic        out_rdy = 1'b0;
  logic        fifo_rd1, fifo_rd2, fifo_rd3, fifo_rd4;
  logic        data_valid, bank_sel, pkt_start, pkt_end, err;

  int n_chk = 0;
  int n_err = 0;

`ifdef PINGPONG_DRAIN_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  pingpong_drain dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .packer_len (packer_len),
    .enable     (enable),
    .wr_a       (wr_a),
    .wr_b       (wr_b),
    .empty_a    (empty_a),
    .empty_b    (empty_b),
    .out_rdy    (out_rdy),
    .fifo_rd1   (fifo_rd1),
    .fifo_rd2   (fifo_rd2),
    .fifo_rd3   (fifo_rd3),
    .fifo_rd4   (fifo_rd4),
    .data_valid (data_valid),
    .bank_sel   (bank_sel),
    .pkt_start  (pkt_start),
    .pkt_end    (pkt_end),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, wa, wb, ea, eb, rdy;
    logic [12:0] len;
    logic        rda, rdb, dv, bs, ps, pe;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act,
                         input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic wa,
                      input logic wb, input logic ea,
                      input logic eb, input logic rdy,
                      input logic [12:0] len);
    @(negedge clk);
    enable     = en;
    wr_a       = wa;
    wr_b       = wb;
    empty_a    = ea;
    empty_b    = eb;
    out_rdy    = rdy;
    packer_len = len;
    ce         = $urandom_range(0, 1) != 0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 13'd0);
    reset = 1'b0;
  endtask

  task automatic add(input logic en, wa, wb, ea, eb, rdy,
                     input logic rda, rdb, dv, bs, ps, pe);
    vec_t v;
    v = '{en, wa, wb, ea, eb, rdy, 13'd4,
          rda, rdb, dv, bs, ps, pe};
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic prv;
    logic [4:0] pat;
    logic [12:0] lens [2];

    // reset with enable and strobes held active
    step(1, 1, 1, 0, 0, 1, 13'd4);
    step(1, 1, 1, 0, 0, 1, 13'd4);
    chk("rst.rd1", fifo_rd1, 1'b0);
    chk("rst.rd3", fifo_rd3, 1'b0);
    chk("rst.dv", data_valid, 1'b0);
    chk("rst.bs", bank_sel, 1'b0);
    chk("rst.ps", pkt_start, 1'b0);
    chk("rst.pe", pkt_end, 1'b0);
    chk("rst.err", err, 1'b0);
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 1, 13'd4);

    // A then B, second A packet written while A is read
    //   en wa wb ea eb rdy  rda rdb dv bs ps pe
    add(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1,   1, 0, 1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 1,   0, 0, 1, 0, 0, 1);
    add(1, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1,   0, 1, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0, 1,   0, 1, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1,   0, 1, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1,   1, 0, 1, 0, 1, 0);
    add(1, 0, 0, 1, 0, 1,   0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 1);

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].wa, tbl[i].wb, tbl[i].ea,
           tbl[i].eb, tbl[i].rdy, tbl[i].len);
      chk($sformatf("row%0d.rd1", i), fifo_rd1, tbl[i].rda);
      chk($sformatf("row%0d.rd2", i), fifo_rd2, tbl[i].rda);
      chk($sformatf("row%0d.rd3", i), fifo_rd3, tbl[i].rdb);
      chk($sformatf("row%0d.rd4", i), fifo_rd4, tbl[i].rdb);
      chk($sformatf("row%0d.dv", i), data_valid, tbl[i].dv);
      if (tbl[i].dv)
        chk($sformatf("row%0d.bs", i), bank_sel, tbl[i].bs);
      chk($sformatf("row%0d.ps", i), pkt_start, tbl[i].ps);
      chk($sformatf("row%0d.pe", i), pkt_end, tbl[i].pe);
      chk($sformatf("row%0d.err", i), err, 1'b0);
    end

    // out_rdy toggling with a 3-word packet
    do_reset();
    step(1, 0, 0, 0, 0, 1, 13'd3);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 1, 13'd3);
    step(1, 0, 0, 0, 0, 1, 13'd3);
    pat = 5'b10101;
    prv = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, pat[4-i], 13'd3);
      chk($sformatf("tog%0d.rd", i), fifo_rd1, pat[4-i]);
      chk($sformatf("tog%0d.dv", i), data_valid, prv);
      if (fifo_rd1) cnt++;
      prv = pat[4-i];
    end
    step(1, 0, 0, 0, 0, 1, 13'd3);
    chk("tog.after_rd", fifo_rd1, 1'b0);
    chk("tog.after_dv", data_valid, 1'b1);
    chk("tog.after_pe", pkt_end, 1'b1);
    chk_int("tog.count", cnt, 3);

    // enable dropped mid-packet, then restart
    do_reset();
    step(1, 0, 0, 0, 0, 1, 13'd4);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 1, 13'd4);
    step(1, 0, 0, 0, 0, 1, 13'd4);
    step(1, 1, 0, 0, 0, 1, 13'd4);
    chk("en.rd_a0", fifo_rd1, 1'b1);
    step(1, 0, 0, 0, 0, 1, 13'd4);
    chk("en.rd_a1", fifo_rd1, 1'b1);
    step(0, 0, 0, 0, 0, 1, 13'd4);
    chk("en.drop_rd", fifo_rd1, 1'b0);
    chk("en.drop_dv", data_valid, 1'b1);
    step(0, 0, 0, 0, 0, 1, 13'd4);
    chk("en.idle_rd", fifo_rd1, 1'b0);
    chk("en.idle_dv", data_valid, 1'b0);
    chk("en.idle_pe", pkt_end, 1'b0);
    step(1, 0, 0, 0, 0, 1, 13'd4);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 1, 13'd4);
      chk($sformatf("en.pend%0d", i), fifo_rd1, 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 1, 13'd4);
    step(1, 0, 0, 0, 0, 1, 13'd4);
    step(1, 0, 0, 0, 0, 1, 13'd4);
    chk("en.wcnt_clr", fifo_rd1, 1'b0);
    step(1, 1, 0, 0, 0, 1, 13'd4);
    step(1, 0, 0, 0, 0, 1, 13'd4);
    step(1, 0, 0, 0, 0, 1, 13'd4);
    chk("en.restart_rd", fifo_rd1, 1'b1);
    step(1, 0, 0, 0, 0, 1, 13'd4);
    chk("en.restart_ps", pkt_start, 1'b1);
    chk("en.restart_bs", bank_sel, 1'b0);

    // reset mid-packet: strobes stop, no pkt_end
    reset = 1'b1;
    step(1, 0, 0, 0, 0, 1, 13'd4);
    chk("midrst.rd", fifo_rd1, 1'b0);
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 1, 13'd4);
    chk("midrst.dv", data_valid, 1'b0);
    chk("midrst.pe", pkt_end, 1'b0);

    // single-word packets; length 0 behaves as 1
    lens[0] = 13'd1;
    lens[1] = 13'd0;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      step(1, 0, 0, 0, 0, 1, lens[k]);
      step(1, 1, 0, 0, 0, 1, lens[k]);
      step(1, 0, 0, 0, 0, 1, lens[k]);
      step(1, 0, 0, 0, 0, 1, lens[k]);
      chk($sformatf("l1_%0d.rd_a", k), fifo_rd1, 1'b1);
      step(1, 0, 1, 0, 0, 1, lens[k]);
      chk($sformatf("l1_%0d.rd_a_off", k), fifo_rd1, 1'b0);
      chk($sformatf("l1_%0d.dv_a", k), data_valid, 1'b1);
      chk($sformatf("l1_%0d.ps_a", k), pkt_start, 1'b1);
      chk($sformatf("l1_%0d.pe_a", k), pkt_end, 1'b1);
      chk($sformatf("l1_%0d.bs_a", k), bank_sel, 1'b0);
      step(1, 0, 0, 0, 0, 1, lens[k]);
      step(1, 0, 0, 0, 0, 1, lens[k]);
      chk($sformatf("l1_%0d.rd_b", k), fifo_rd3, 1'b1);
      step(1, 0, 0, 0, 0, 1, lens[k]);
      chk($sformatf("l1_%0d.dv_b", k), data_valid, 1'b1);
      chk($sformatf("l1_%0d.ps_b", k), pkt_start, 1'b1);
      chk($sformatf("l1_%0d.pe_b", k), pkt_end, 1'b1);
      chk($sformatf("l1_%0d.bs_b", k), bank_sel, 1'b1);
    end

    // pend overflow: 8 packets written, none drained
    do_reset();
    step(1, 0, 0, 0, 0, 0, 13'd1);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 0, 0, 0, 13'd1);
      chk($sformatf("ovf%0d.err", i), err, 1'b0);
      chk($sformatf("ovf%0d.rd", i), fifo_rd1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 0, 13'd1);
      chk($sformatf("ovf.hold%0d", i), err, EXP_ERR);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
